// File: rtl/pw_feeder.sv
// Pointwise-conv feeder: buffers one pixel's depthwise outputs, then replays them
// once per output channel with framing flags and weight-address indices.
module pw_feeder #(
  parameter int DATA_W     = 8,
  parameter int MAX_IN_CH  = 1024,
  parameter int MAX_OUT_CH = 1024,
  parameter int MAX_PIX    = 50176,
  localparam int CH_W  = $clog2(MAX_IN_CH + 1),
  localparam int OCH_W = $clog2(MAX_OUT_CH + 1),
  localparam int PIX_W = $clog2(MAX_PIX + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CH_W-1:0]          cfg_in_ch,
  input  logic [OCH_W-1:0]         cfg_out_ch,
  input  logic [PIX_W-1:0]         cfg_num_pix,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_first_in_ch,
  output logic                     out_last_in_ch,
  output logic [CH_W-1:0]          out_in_ch_idx,
  output logic [OCH_W-1:0]         out_out_ch_idx,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = (MAX_IN_CH > 1) ? $clog2(MAX_IN_CH) : 1;

  typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_t;
  state_t state, state_nx;

  logic [CH_W-1:0]  in_ch_q, wr_ptr, rd_ich;
  logic [OCH_W-1:0] out_ch_q, rd_och;
  logic [PIX_W-1:0] num_pix_q, pix_cnt;
  logic             pending;
  logic signed [DATA_W-1:0] buf_mem [MAX_IN_CH];

  logic cfg_zero, in_fire, out_fire, last_wr, final_beat, load, last_pix;
  logic [CH_W-1:0]  in_ch_last;
  logic [OCH_W-1:0] out_ch_last;

  always_comb begin
    in_ch_last  = in_ch_q - CH_W'(1);
    out_ch_last = out_ch_q - OCH_W'(1);
    cfg_zero    = (cfg_in_ch == '0) || (cfg_out_ch == '0) || (cfg_num_pix == '0);
    in_fire     = in_valid && in_ready;
    out_fire    = out_valid && out_ready;
    last_wr     = (wr_ptr == in_ch_last);
    final_beat  = (state == REPLAY) && out_fire &&
                  (out_in_ch_idx == in_ch_last) && (out_out_ch_idx == out_ch_last);
    // Single output register: refill whenever it is empty or draining this cycle.
    load        = (state == REPLAY) && pending && (!out_valid || out_ready);
    last_pix    = ((pix_cnt + PIX_W'(1)) == num_pix_q);
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:   if (start && !cfg_zero) state_nx = FILL;
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && last_wr) state_nx = REPLAY;
      end
      REPLAY: if (final_beat) state_nx = last_pix ? IDLE : FILL;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_fire) buf_mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      in_ch_q         <= '0;
      out_ch_q        <= '0;
      num_pix_q       <= '0;
      wr_ptr          <= '0;
      rd_ich          <= '0;
      rd_och          <= '0;
      pix_cnt         <= '0;
      pending         <= 1'b0;
      done            <= 1'b0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_first_in_ch <= 1'b0;
      out_last_in_ch  <= 1'b0;
      out_in_ch_idx   <= '0;
      out_out_ch_idx  <= '0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          in_ch_q   <= cfg_in_ch;
          out_ch_q  <= cfg_out_ch;
          num_pix_q <= cfg_num_pix;
          pix_cnt   <= '0;
          wr_ptr    <= '0;
          if (cfg_zero) done <= 1'b1;
        end
        FILL: if (in_fire) begin
          if (last_wr) begin
            wr_ptr  <= '0;
            rd_ich  <= '0;
            rd_och  <= '0;
            pending <= 1'b1;
          end else begin
            wr_ptr <= wr_ptr + CH_W'(1);
          end
        end
        REPLAY: begin
          if (load) begin
            out_valid       <= 1'b1;
            out_data        <= buf_mem[rd_ich[AW-1:0]];
            out_in_ch_idx   <= rd_ich;
            out_out_ch_idx  <= rd_och;
            out_first_in_ch <= (rd_ich == '0);
            out_last_in_ch  <= (rd_ich == in_ch_last);
            if (rd_ich == in_ch_last) begin
              rd_ich <= '0;
              if (rd_och == out_ch_last) begin
                rd_och  <= '0;
                pending <= 1'b0;
              end else begin
                rd_och <= rd_och + OCH_W'(1);
              end
            end else begin
              rd_ich <= rd_ich + CH_W'(1);
            end
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
          if (final_beat) begin
            if (last_pix) begin
              pix_cnt <= '0;
              done    <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + PIX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pw_feeder.sv
// Self-checking bench for pw_feeder: a per-job beat list built from the replay
// rules is compared against every output handshake, with phase and stall checks.
module tb_pw_feeder;
  localparam int DW  = 8;
  localparam int MIC = 16;
  localparam int MOC = 8;
  localparam int MP  = 16;
  localparam int CW  = $clog2(MIC + 1);
  localparam int OW  = $clog2(MOC + 1);
  localparam int PW  = $clog2(MP + 1);

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] cfg_in_ch, out_in_ch_idx;
  logic [OW-1:0] cfg_out_ch, out_out_ch_idx;
  logic [PW-1:0] cfg_num_pix;
  logic signed [DW-1:0] in_data, out_data;
  logic out_first_in_ch, out_last_in_ch, busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic signed [DW-1:0] d;
    int ic;
    int oc;
  } beat_t;

  logic signed [DW-1:0] din[$];

  pw_feeder #(.DATA_W(DW), .MAX_IN_CH(MIC), .MAX_OUT_CH(MOC), .MAX_PIX(MP)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch), .cfg_num_pix(cfg_num_pix),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first_in_ch(out_first_in_ch), .out_last_in_ch(out_last_in_ch),
    .out_in_ch_idx(out_in_ch_idx), .out_out_ch_idx(out_out_ch_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // mode: 0 = ready always high, 1 = ready toggles 1,0,..., 2 = random valid/ready
  task automatic run_job(input int ich, input int och, input int npix, input int mode,
                         input int abort_after, input bit poke);
    beat_t exp_q[$];
    beat_t b;
    int total = npix * ich;
    int fed = 0, seen = 0, cyc = 0, rc = 0;
    bit fill = 1, prev_stall = 0, finished = 0, aborted = 0;
    logic signed [DW-1:0] prev_d;
    int prev_ic = 0, prev_oc = 0;

    for (int p = 0; p < npix; p++)
      for (int o = 0; o < och; o++)
        for (int i = 0; i < ich; i++) begin
          b.d = din[p * ich + i]; b.ic = i; b.oc = o;
          exp_q.push_back(b);
        end

    @(negedge clk);
    cfg_in_ch = CW'(ich); cfg_out_ch = OW'(och); cfg_num_pix = PW'(npix);
    start = 1'b1;
    while (!finished && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start = (poke && cyc == 2);
      if (cyc == 1) begin
        cfg_in_ch = CW'(1); cfg_out_ch = OW'(1); cfg_num_pix = PW'(1);
      end

      checks++;
      if (in_ready !== fill || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL phase cyc=%0d: in_ready=%b busy=%b done=%b, required in_ready=%b busy=1 done=0",
                 cyc, in_ready, busy, done, fill);
      if (fill) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL fill_out_valid cyc=%0d: out_valid=%b, required 0", cyc, out_valid);
        end
      end else if (rc == 0 || mode == 0) begin
        checks++;
        if (out_valid !== (rc != 0)) begin
          errors++;
          $display("FAIL replay_valid cyc=%0d rc=%0d: out_valid=%b, required %b",
                   cyc, rc, out_valid, rc != 0);
        end
      end
      if (in_ready !== fill || busy !== 1'b1 || done !== 1'b0) errors++;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_d ||
            out_in_ch_idx !== CW'(prev_ic) || out_out_ch_idx !== OW'(prev_oc)) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d: valid=%b data=%0d ic=%0d oc=%0d, required 1 %0d %0d %0d",
                   cyc, out_valid, out_data, out_in_ch_idx, out_out_ch_idx, prev_d, prev_ic, prev_oc);
        end
      end

      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2 == 1);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (mode == 2) in_valid = ($urandom_range(0, 3) != 0);
      else in_valid = fill && (fed < total);
      in_data = (fed < total) ? din[fed] : DW'($urandom);

      if (!fill) rc++;
      if (in_valid && in_ready) begin
        fed++;
        if (fed % ich == 0) begin fill = 0; rc = 0; end
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data; prev_ic = out_in_ch_idx; prev_oc = out_out_ch_idx;

      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat cyc=%0d: data=%0d, required no beat", cyc, out_data);
        end else begin
          b = exp_q.pop_front();
          if (out_data !== b.d || out_in_ch_idx !== CW'(b.ic) || out_out_ch_idx !== OW'(b.oc) ||
              out_first_in_ch !== (b.ic == 0) || out_last_in_ch !== (b.ic == ich - 1)) begin
            errors++;
            $display("FAIL beat%0d: data=%0d ic=%0d oc=%0d first=%b last=%b, required %0d %0d %0d %b %b",
                     seen, out_data, out_in_ch_idx, out_out_ch_idx, out_first_in_ch, out_last_in_ch,
                     b.d, b.ic, b.oc, b.ic == 0, b.ic == ich - 1);
          end
          seen++;
          if (seen % (ich * och) == 0) begin
            if (exp_q.size() == 0) finished = 1;
            else fill = 1;
          end
          if (abort_after > 0 && seen == abort_after) begin
            aborted = 1; finished = 1;
          end
        end
      end
    end

    if (!finished) begin
      errors++; checks++;
      $display("FAIL timeout: beats=%0d, required %0d", seen, ich * och * npix);
    end

    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    if (aborted) begin
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL abort_async: valid=%b busy=%b in_ready=%b done=%b, required all 0",
                 out_valid, busy, in_ready, done);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_in_ch_idx !== '0) begin
        errors++;
        $display("FAIL abort_edge: valid=%b busy=%b data=%0d ic=%0d, required 0 0 0 0",
                 out_valid, busy, out_data, out_in_ch_idx);
      end
      @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL abort_no_done k=%0d: done=%b busy=%b, required 0 0", k, done, busy);
        end
      end
    end else if (finished) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL job_done: done=%b busy=%b in_ready=%b valid=%b, required 1 0 0 0",
                 done, busy, in_ready, out_valid);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse_width: done=%b, required 0", done);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    cfg_in_ch = '0; cfg_out_ch = '0; cfg_num_pix = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        out_data !== '0 || out_first_in_ch !== 1'b0 || out_last_in_ch !== 1'b0 ||
        out_in_ch_idx !== '0 || out_out_ch_idx !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b rdy=%b busy=%b done=%b data=%0d ic=%0d oc=%0d, required all 0",
               out_valid, in_ready, busy, done, out_data, out_in_ch_idx, out_out_ch_idx);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    din = '{8'sd10, -8'sd3, 8'sd7, 8'sd127};
    run_job(4, 2, 1, 0, 0, 0);
  endtask

  task automatic test_stall();
    din = '{8'sd10, -8'sd3, 8'sd7, 8'sd127};
    run_job(4, 2, 1, 1, 0, 0);
  endtask

  task automatic test_single_ch();
    din = '{-8'sd128, 8'sd5};
    run_job(1, 3, 2, 0, 0, 0);
  endtask

  task automatic test_zero_cfg();
    @(negedge clk);
    cfg_in_ch = CW'(3); cfg_out_ch = '0; cfg_num_pix = PW'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_cfg: done=%b busy=%b valid=%b rdy=%b, required 1 0 0 0",
               done, busy, out_valid, in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_cfg_after k=%0d: done=%b busy=%b valid=%b, required 0 0 0",
                 k, done, busy, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    din = '{8'sd10, -8'sd3, 8'sd7, 8'sd127};
    run_job(4, 2, 1, 0, 3, 0);
    din = '{8'sd1, 8'sd2, 8'sd4, 8'sd8};
    run_job(4, 2, 1, 0, 0, 0);
  endtask

  task automatic test_start_ignored();
    din = '{8'sd10, -8'sd3, 8'sd7, 8'sd127};
    run_job(4, 2, 1, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      int ich = $urandom_range(1, MIC);
      int och = $urandom_range(1, 4);
      int np  = $urandom_range(1, 3);
      din.delete();
      for (int k = 0; k < ich * np; k++) din.push_back(DW'($urandom));
      run_job(ich, och, np, 2, 0, (j % 2 == 1));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_single_ch();
    test_zero_cfg();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pw_feeder.md
PW_FEEDER -- requirements
Module: pw_feeder

Interface
REQ-001 Parameter DATA_W, default 8, activation width.
REQ-002 Parameter MAX_IN_CH, default 1024, channel buffer depth; CH_W = $clog2(MAX_IN_CH+1).
REQ-003 Parameter MAX_OUT_CH, default 1024; OCH_W = $clog2(MAX_OUT_CH+1).
REQ-004 Parameter MAX_PIX, default 50176; PIX_W = $clog2(MAX_PIX+1).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  one-cycle job launch pulse.
REQ-008 cfg_in_ch  in  CH_W  input channels per pixel (count, not count-1).
REQ-009 cfg_out_ch  in  OCH_W  output channels per pixel.
REQ-010 cfg_num_pix  in  PIX_W  pixels in job.
REQ-011 in_valid / in_ready  in / out  1 each  depthwise-output stream handshake.
REQ-012 in_data  in  DATA_W signed  depthwise result, pixel-major, channel-minor.
REQ-013 out_valid / out_ready  out / in  1 each  pointwise-input handshake.
REQ-014 out_data  out  DATA_W signed  buffered activation.
REQ-015 out_first_in_ch, out_last_in_ch  out  1 each  accumulation framing flags.
REQ-016 out_in_ch_idx  out  CH_W  input-channel index of out_data (weight address).
REQ-017 out_out_ch_idx  out  OCH_W  current output channel (weight/bias address).
REQ-018 busy  out  1  high outside IDLE; done  out  1  one-cycle job-complete pulse.

Function
REQ-019 States: IDLE, FILL, REPLAY; cfg_* latched on start accepted in IDLE; start ignored elsewhere.
REQ-020 IDLE + start with any cfg field zero: stay IDLE, pulse done next cycle, no output beats.
REQ-021 IDLE + start, all cfg nonzero: go FILL, pixel count 0, write pointer 0.
REQ-022 FILL: in_ready=1; each in_valid&&in_ready writes in_data to buf[wr_ptr], wr_ptr++.
REQ-023 FILL: acceptance of beat cfg_in_ch-1 moves to REPLAY next cycle; wr_ptr cleared.
REQ-024 In REPLAY and IDLE in_ready=0; buffer contents are never overwritten while replaying.
REQ-025 REPLAY emits cfg_out_ch passes, each pass cfg_in_ch beats, in_ch index 0..cfg_in_ch-1, out_ch index 0..cfg_out_ch-1.
REQ-026 Output is a single registered stage: out_* load from buf[rd_idx] and counters whenever (!out_valid || out_ready) and beats remain.
REQ-027 First out_valid asserts the cycle after entering REPLAY; sustained out_ready gives one beat per cycle, no bubbles across pass boundaries.
REQ-028 out_first_in_ch=1 iff out_in_ch_idx==0; out_last_in_ch=1 iff out_in_ch_idx==cfg_in_ch-1; both high when cfg_in_ch==1.
REQ-029 out_valid held with out_* stable until out_ready; data never changes while out_valid&&!out_ready.
REQ-030 After final beat (out_ch cfg_out_ch-1, in_ch cfg_in_ch-1) handshakes: pixel count++; if count==cfg_num_pix go IDLE and pulse done, else go FILL.
REQ-031 FILL re-entry for next pixel occurs the cycle after final beat handshake; in_ready rises that cycle.
REQ-032 busy=1 in FILL and REPLAY; done coincides with IDLE return cycle.
REQ-033 Counters wrap only by explicit clear at terminal counts; no modulo wrap of indices.
REQ-034 Buffer implemented as MAX_IN_CH x DATA_W array, one write port, one read port.

Reset
REQ-035 rst asserted: state IDLE, out_valid=0, in_ready=0, busy=0, done=0, all counters 0, out_data/flags/indices 0; buffer contents undefined.
REQ-036 rst mid-job aborts immediately; no done pulse; next start begins a fresh job.

Verification
REQ-037 cfg_in_ch=4, cfg_out_ch=2, cfg_num_pix=1, in 10,-3,7,127, out_ready=1 -> 8 beats 10,-3,7,127,10,-3,7,127; first flag on beats 0,4; last on 3,7; out_ch idx 0x4 then 1x4; done once.
REQ-038 Same job, out_ready toggled 1,0 each cycle -> identical beat sequence, out_data stable during every stall, no beat lost or duplicated.
REQ-039 cfg_in_ch=1, cfg_out_ch=3, cfg_num_pix=2, in -128 then 5 -> out -128 x3 then 5 x3, first=last=1 every beat, in_ready low during replay, done after 6th beat.
REQ-040 start with cfg_out_ch=0 -> no out_valid, done pulse one cycle later, busy stays 0.
REQ-041 Assert rst during REPLAY of REQ-037 after beat 2 -> out_valid=0 next edge, no done; new start with in 1,2,4,8 replays 1,2,4,8 cleanly.
REQ-042 start pulsed during FILL -> ignored; job completes with originally latched cfg.
